// File: rtl/halt_checker.sv
// halt_checker: waits for the core to halt, sums a window of data SRAM words,
// reads a reference word and reports pass/fail. Gives up with a timeout if the
// core never halts. Results are sticky until reset.
module halt_checker #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int SUM_BASE  = 0,
  parameter int SUM_COUNT = 16,
  parameter int REF_ADDR  = 16,
  parameter int SUM_BIAS  = 1,
  parameter int TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-1:0] sum_out,
  output logic [DATA_W-1:0] ref_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter values of interest. In SCAN the counter holds (edges since E0) - 1
  // before each edge, so the edge Ek sees cnt_q == k-1.
  localparam logic [31:0]       TO_LAST     = 32'(TIMEOUT - 1);
  localparam logic [31:0]       CNT_LASTSUM = 32'(SUM_COUNT - 1);
  localparam logic [31:0]       CNT_SUM     = 32'(SUM_COUNT);
  localparam logic [31:0]       CNT_REF     = 32'(SUM_COUNT + 1);
  localparam logic [ADDR_W-1:0] BASE_A      = ADDR_W'(SUM_BASE);
  localparam logic [ADDR_W-1:0] REF_A       = ADDR_W'(REF_ADDR);
  localparam logic [ADDR_W-1:0] ONE_A       = ADDR_W'(1);
  localparam logic [DATA_W-1:0] BIAS_D      = DATA_W'(SUM_BIAS);

  state_t              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                timeout_q, timeout_d;
  logic [DATA_W-1:0]   sum_out_q, sum_out_d;
  logic [DATA_W-1:0]   ref_out_q, ref_out_d;
  logic [DATA_W-1:0]   biased_s;

  assign biased_s = sum_q - BIAS_D;

  // Next-state and next-output computation for the whole checker.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    rd_en_d   = 1'b0;
    addr_d    = {ADDR_W{1'b0}};
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    sum_out_d = sum_out_q;
    ref_out_d = ref_out_q;
    case (state_q)
      IDLE: begin
        if (halted) begin
          // Halt wins over a coincident timeout.
          state_d = SCAN;
          cnt_d   = 32'd0;
          sum_d   = {DATA_W{1'b0}};
          rd_en_d = 1'b1;
          addr_d  = BASE_A;
        end else if (cnt_q == TO_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          pass_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + 32'd1;
        // Issue reads 1..SUM_COUNT; the last one fetches the reference word.
        if (cnt_q < CNT_SUM) begin
          rd_en_d = 1'b1;
          if (cnt_q < CNT_LASTSUM) begin
            addr_d = BASE_A + cnt_q[ADDR_W-1:0] + ONE_A;
          end else begin
            addr_d = REF_A;
          end
        end else begin
          rd_en_d = 1'b0;
          addr_d  = {ADDR_W{1'b0}};
        end
        // Read data lands two edges after issue: summed words first, then ref.
        if ((cnt_q >= 32'd1) && (cnt_q <= CNT_SUM)) begin
          sum_d = sum_q + mem_rdata;
        end else begin
          sum_d = sum_q;
        end
        if (cnt_q == CNT_REF) begin
          ref_out_d = mem_rdata;
          state_d   = CMP;
        end else begin
          ref_out_d = ref_out_q;
        end
      end
      CMP: begin
        state_d   = DONE;
        sum_out_d = biased_s;
        done_d    = 1'b1;
        pass_d    = (biased_s == ref_out_q);
        fail_d    = (biased_s != ref_out_q);
        timeout_d = 1'b0;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 32'd0;
      sum_q     <= {DATA_W{1'b0}};
      rd_en_q   <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      sum_out_q <= {DATA_W{1'b0}};
      ref_out_q <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      sum_out_q <= sum_out_d;
      ref_out_q <= ref_out_d;
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign sum_out   = sum_out_q;
  assign ref_out   = ref_out_q;

endmodule

// File: tb/tb_halt_checker.sv
// Directed bench for halt_checker with a behavioural one-cycle-latency SRAM.
module tb_halt_checker;

  logic        clk;
  logic        rst_n;
  logic        halted;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        done, pass, fail, timeout;
  logic [31:0] sum_out, ref_out;

  logic [31:0] mem [0:1023];
  logic [9:0]  rd_log [$];
  int          viol;
  int          n_checks;
  int          n_fail;

  halt_checker #(.TIMEOUT(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .halted    (halted),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .timeout   (timeout),
    .sum_out   (sum_out),
    .ref_out   (ref_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: address sampled on the edge, data valid the following cycle.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_log.push_back(mem_addr);
    end
  end

  // Invariant monitor: idle address is zero, pass/fail exclusive, done covers them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_rd_en && (mem_addr != 10'd0)) viol++;
      if (pass && fail) viol++;
      if ((pass || fail) && !done) viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_flags"}, {60'd0, done, pass, fail, timeout}, 64'd0);
    check({tag, "_sum"}, {32'd0, sum_out}, 64'd0);
    check({tag, "_ref"}, {32'd0, ref_out}, 64'd0);
    check({tag, "_rd"}, {53'd0, mem_rd_en, mem_addr}, 64'd0);
  endtask

  task automatic load_mem(input logic [31:0] w, input bit ramp, input logic [31:0] refw);
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 + i;
    for (int i = 0; i < 16; i++) mem[i] = ramp ? (i + 1) : w;
    mem[16] = refw;
  endtask

  // Reset held for two edges; released on a falling edge so the next rising edge is edge 1.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n  = 1'b0;
    halted = 1'b0;
    #1;
    check_outputs_zero({tag, "_inrst"});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_log.delete();
  endtask

  // Raises halted for edge E0, then expects the result at E0+19 with 17 reads 0..16.
  task automatic run_scan(input string tag, input bit exp_pass,
                          input logic [31:0] exp_sum, input logic [31:0] exp_ref);
    int k;
    int bad;
    @(negedge clk);
    halted = 1'b1;
    @(posedge clk);
    #1;
    halted = 1'b0;
    k = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        k = e;
        break;
      end
    end
    check({tag, "_latency"}, 64'(k), 64'd19);
    check({tag, "_flags"}, {60'd0, done, pass, fail, timeout},
          {60'd0, 1'b1, exp_pass, !exp_pass, 1'b0});
    check({tag, "_sum"}, {32'd0, sum_out}, {32'd0, exp_sum});
    check({tag, "_ref"}, {32'd0, ref_out}, {32'd0, exp_ref});
    check({tag, "_nreads"}, 64'(rd_log.size()), 64'd17);
    bad = 0;
    for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != 10'(i)) bad++;
    check({tag, "_addrs"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int early;
    n_checks  = 0;
    n_fail    = 0;
    viol      = 0;
    rst_n     = 1'b0;
    halted    = 1'b0;
    mem_rdata = 32'd0;
    load_mem(32'd0, 1'b1, 32'd135);

    // Basic pass: sum 136, minus bias 1 = 135.
    do_reset("rst0");
    repeat (3) @(posedge clk);
    run_scan("pass", 1'b1, 32'd135, 32'd135);

    // Sticky DONE: halted toggles, nothing changes and no reads occur.
    rd_log.delete();
    @(negedge clk);
    halted = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    halted = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sticky_flags", {60'd0, done, pass, fail, timeout}, {60'd0, 4'b1100});
    check("sticky_sum", {32'd0, sum_out}, 64'd135);
    check("sticky_reads", 64'(rd_log.size()), 64'd0);

    // Mismatching reference word.
    load_mem(32'd0, 1'b1, 32'd136);
    do_reset("rst1");
    run_scan("mismatch", 1'b0, 32'd135, 32'd136);

    // Wrap-around: 16 * 0xFFFFFFFF - 1 = 0xFFFFFFEF.
    load_mem(32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFEF);
    do_reset("rst2");
    run_scan("wrap", 1'b1, 32'hFFFF_FFEF, 32'hFFFF_FFEF);

    // Timeout on edge 100 after release with halted never high.
    do_reset("rst3");
    early = 0;
    for (int e = 1; e <= 99; e++) begin
      @(posedge clk);
      #1;
      if (done || timeout) early++;
    end
    @(posedge clk);
    #1;
    check("to_early", 64'(early), 64'd0);
    check("to_flags", {60'd0, done, pass, fail, timeout}, {60'd0, 4'b1011});
    check("to_reads", 64'(rd_log.size()), 64'd0);

    // Halt on edge 100 beats the timeout.
    load_mem(32'd0, 1'b1, 32'd135);
    do_reset("rst4");
    repeat (99) @(posedge clk);
    run_scan("edge100", 1'b1, 32'd135, 32'd135);

    // Reset in the middle of SCAN, then a clean rerun.
    do_reset("rst5");
    @(negedge clk);
    halted = 1'b1;
    @(posedge clk);
    #1;
    halted = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midscan_nreads", 64'(rd_log.size()), 64'd5);
    check("midscan_rden", {63'd0, mem_rd_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midscan_rst");
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("midscan_hold");
    @(negedge clk);
    rst_n = 1'b1;
    rd_log.delete();
    run_scan("rerun", 1'b1, 32'd135, 32'd135);

    check("invariants", 64'(viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/halt_checker.md
HALT_CHECKER -- requirements
Module: halt_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32: memory word and checksum width.
REQ-002 SHALL have parameter ADDR_W, default 10: memory word-address width.
REQ-003 SHALL have parameter SUM_BASE, default 0: first word address summed.
REQ-004 SHALL have parameter SUM_COUNT, default 16: number of consecutive words summed; legal range 1..2^ADDR_W-1.
REQ-005 SHALL have parameter REF_ADDR, default 16: word address of the reference value.
REQ-006 SHALL have parameter SUM_BIAS, default 1: constant subtracted from the sum before compare.
REQ-007 SHALL have parameter TIMEOUT, default 50000: cycles allowed in IDLE before timeout; legal range >=1.
REQ-008 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-009 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-010 SHALL have port halted, input, 1: core halt indication, level, sampled on clk.
REQ-011 SHALL have port mem_rd_en, output, 1: read strobe to data SRAM.
REQ-012 SHALL have port mem_addr, output, ADDR_W: word address for the read.
REQ-013 SHALL have port mem_rdata, input, DATA_W: read data, valid the cycle after the edge on which mem_rd_en/mem_addr are sampled.
REQ-014 SHALL have ports done, pass, fail, timeout, outputs, 1 each: result flags.
REQ-015 SHALL have port sum_out, output, DATA_W: biased checksum (sum minus SUM_BIAS).
REQ-016 SHALL have port ref_out, output, DATA_W: captured reference word.

Function
REQ-017 SHALL implement states IDLE, SCAN, CMP, DONE.
REQ-018 In IDLE, SHALL increment a cycle counter each clock; halted sampled high at edge E0 SHALL move to SCAN.
REQ-019 In IDLE, if the counter reaches TIMEOUT-1 with halted low, SHALL move to DONE with timeout=1, fail=1, pass=0.
REQ-020 Halted high on the same edge as timeout SHALL take priority (move to SCAN, no timeout).
REQ-021 In SCAN, SHALL assert mem_rd_en for exactly SUM_COUNT+1 consecutive cycles starting the cycle after E0: addresses SUM_BASE..SUM_BASE+SUM_COUNT-1 in order, then REF_ADDR.
REQ-022 Data of read i (issued after edge Ei) SHALL be captured at edge Ei+2; summed words accumulate modulo 2^DATA_W, the final word loads ref_out.
REQ-023 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-024 CMP SHALL compute sum_out = (sum - SUM_BIAS) mod 2^DATA_W and, at edge E(SUM_COUNT+3), enter DONE with done=1 and pass=(sum_out==ref_out), fail=!pass.
REQ-025 mem_rd_en SHALL be 0 in IDLE, CMP and DONE; mem_addr SHALL be 0 when mem_rd_en is 0.
REQ-026 halted deasserting during SCAN/CMP SHALL be ignored.
REQ-027 DONE SHALL be sticky: flags, sum_out, ref_out held until reset; halted ignored.
REQ-028 pass and fail SHALL never both be 1; done SHALL be 1 whenever pass or fail is 1.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counter 0, all outputs 0, from any state including mid-SCAN.
REQ-030 After rst_n rises, the timeout count SHALL restart from 0 on the first rising clk edge.

Verification
REQ-031 Words 0..15 = 1..16, word 16 = 135, halted at E0 -> done=1, pass=1 at E0+19; sum_out=135, ref_out=135; exactly 17 reads, addresses 0..16.
REQ-032 Same data, word 16 = 136 -> done=1, fail=1, sum_out=135, ref_out=136.
REQ-033 Words 0..15 = 32'hFFFFFFFF, word 16 = 32'hFFFFFFEF -> pass=1 (wrap-around).
REQ-034 TIMEOUT=100, halted never asserted -> done=timeout=fail=1 on the 100th edge after reset release; mem_rd_en never asserted.
REQ-035 TIMEOUT=100, halted first high on edge 100 -> no timeout, SCAN proceeds, pass per data.
REQ-036 rst_n pulsed low during SCAN (after 5 reads), then halted again -> outputs 0 during reset; full 17-read scan repeats, correct result.
